// File: rtl/inst_mem_responder.sv
// Read-only instruction memory slave: accepts one read address at a time and
// returns a 1-8 beat INCR burst of 32-bit words from a side-band preloaded array.
module inst_mem_responder #(
  parameter int ADDR_BITS = 12,
  parameter int LATENCY   = 2,
  parameter int BEAT_GAP  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          s_araddr,
  input  logic [2:0]           s_arlen,
  input  logic                 s_arvalid,
  output logic                 s_arready,
  output logic [31:0]          s_rdata,
  output logic                 s_rvalid,
  output logic                 s_rlast,
  input  logic                 s_rready,
  input  logic                 ld_en,
  input  logic [ADDR_BITS-1:0] ld_addr,
  input  logic [31:0]          ld_data
);

  localparam int DEPTH   = 1 << ADDR_BITS;
  localparam int MAX_CNT = (LATENCY > BEAT_GAP) ? LATENCY : BEAT_GAP;
  localparam int CNT_W   = (MAX_CNT < 2) ? 1 : $clog2(MAX_CNT);
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'((LATENCY > 0) ? LATENCY - 1 : 0);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'((BEAT_GAP > 0) ? BEAT_GAP - 1 : 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_LOAD,
    ST_BEAT,
    ST_GAP
  } state_t;

  state_t                 r_state;
  logic [ADDR_BITS-1:0]   r_idx;
  logic [2:0]             r_len;
  logic [2:0]             r_beat;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_arready;
  logic [31:0]            r_rdata;
  logic [31:0]            r_mem [DEPTH];

  state_t                 w_state_nxt;
  logic [ADDR_BITS-1:0]   w_idx_nxt;
  logic [2:0]             w_len_nxt;
  logic [2:0]             w_beat_nxt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic                   w_last;
  logic                   w_unused;

  // Address bits outside the word index are deliberately ignored (aliasing).
  assign w_unused = ^{s_araddr[31:ADDR_BITS+2], s_araddr[1:0]};

  assign w_last = (r_beat == r_len);

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_len_nxt   = r_len;
    w_beat_nxt  = r_beat;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (s_arvalid && r_arready) begin
          w_idx_nxt  = s_araddr[ADDR_BITS+1:2];
          w_len_nxt  = s_arlen;
          w_beat_nxt = 3'd0;
          if (LATENCY > 0) begin
            w_cnt_nxt   = LAT_LOAD;
            w_state_nxt = ST_WAIT;
          end else begin
            w_state_nxt = ST_LOAD;
          end
        end
      end
      ST_WAIT, ST_GAP: begin
        if (r_cnt == '0) w_state_nxt = ST_LOAD;
        else             w_cnt_nxt   = r_cnt - 1'b1;
      end
      ST_LOAD: w_state_nxt = ST_BEAT;
      ST_BEAT: begin
        if (s_rready) begin
          if (w_last) begin
            w_state_nxt = ST_IDLE;
          end else begin
            // INCR addressing; the index rolls over naturally at DEPTH.
            w_idx_nxt  = r_idx + 1'b1;
            w_beat_nxt = r_beat + 1'b1;
            if (BEAT_GAP > 0) begin
              w_cnt_nxt   = GAP_LOAD;
              w_state_nxt = ST_GAP;
            end else begin
              w_state_nxt = ST_LOAD;
            end
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // arready is registered so it stays low through reset and rises one edge later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_len     <= '0;
      r_beat    <= '0;
      r_cnt     <= '0;
      r_arready <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_len     <= w_len_nxt;
      r_beat    <= w_beat_nxt;
      r_cnt     <= w_cnt_nxt;
      r_arready <= (w_state_nxt == ST_IDLE);
      if (r_state == ST_LOAD) r_rdata <= r_mem[r_idx];
    end
  end

  // Array contents survive reset; a same-edge write is not seen by a LOAD.
  always_ff @(posedge clk) begin
    if (ld_en) r_mem[ld_addr] <= ld_data;
  end

  assign s_arready = r_arready;
  assign s_rdata   = r_rdata;
  assign s_rvalid  = (r_state == ST_BEAT);
  assign s_rlast   = (r_state == ST_BEAT) && w_last;

endmodule

// File: tb/tb_inst_mem_responder.sv
// Directed bench for inst_mem_responder: bursts, backpressure, wrap, reset and preload.
module tb_inst_mem_responder;
  localparam int ADDR_BITS = 12;
  localparam int DEPTH     = 1 << ADDR_BITS;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [31:0]          s_araddr;
  logic [2:0]           s_arlen;
  logic                 s_arvalid;
  logic                 s_arready;
  logic [31:0]          s_rdata;
  logic                 s_rvalid;
  logic                 s_rlast;
  logic                 s_rready;
  logic                 ld_en;
  logic [ADDR_BITS-1:0] ld_addr;
  logic [31:0]          ld_data;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] got_data [16];
  logic        got_last [16];
  int          got_edge [16];
  logic [31:0] hold_data [8];
  logic        hold_vld  [8];
  int          n_hold;
  int          ar_hi;

  always #5 clk = ~clk;

  inst_mem_responder #(.ADDR_BITS(ADDR_BITS), .LATENCY(2), .BEAT_GAP(0)) dut (
    .clk(clk), .rst(rst),
    .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rvalid(s_rvalid), .s_rlast(s_rlast), .s_rready(s_rready),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic preload_all();
    for (int i = 0; i < 32; i++) begin
      @(negedge clk); ld_en = 1'b1; ld_addr = ADDR_BITS'(i); ld_data = 32'h1000_0000 + 32'(i);
    end
    @(negedge clk); ld_en = 1'b1; ld_addr = ADDR_BITS'(DEPTH - 2); ld_data = 32'hA5A5_0FFE;
    @(negedge clk); ld_en = 1'b1; ld_addr = ADDR_BITS'(DEPTH - 1); ld_data = 32'hA5A5_0FFF;
    @(negedge clk); ld_en = 1'b0;
  endtask

  // Returns just after the AR handshake edge.
  task automatic issue_ar(input logic [31:0] a, input logic [2:0] l, output bit tmo);
    int k;
    tmo = 0; k = 0;
    @(negedge clk); s_araddr = a; s_arlen = l; s_arvalid = 1'b1;
    while (!s_arready && k < 100) begin @(negedge clk); k++; end
    if (!s_arready) tmo = 1;
    @(posedge clk); #1 s_arvalid = 1'b0;
  endtask

  // Collects beats; got_edge[i] = edges after the AR handshake at which beat i completes.
  task automatic run_burst(input int stall_beat, input int stall_cyc, output int nb, output bit tmo);
    int e; int left; bit last;
    nb = 0; tmo = 0; e = 0; left = stall_cyc; n_hold = 0; ar_hi = 0; last = 0;
    s_rready = 1'b1;
    while (!last && !tmo && nb < 16) begin
      @(negedge clk); e++;
      if (e >= 2) ld_en = 1'b0;
      if (s_arready) ar_hi++;
      if (e > 200) tmo = 1;
      else if (nb == stall_beat && left > 0 && (s_rvalid || n_hold > 0)) begin
        s_rready = 1'b0; hold_data[n_hold] = s_rdata; hold_vld[n_hold] = s_rvalid;
        n_hold++; left--;
      end else if (s_rvalid) begin
        s_rready = 1'b1; got_data[nb] = s_rdata; got_last[nb] = s_rlast; got_edge[nb] = e;
        nb++; last = s_rlast;
      end else s_rready = 1'b1;
    end
  endtask

  task automatic test_reset();
    #12;
    n_checks++; if (s_arready !== 1'b0) begin n_errors++; $display("FAIL reset_arready: got %b expected 0", s_arready); end
    n_checks++; if (s_rvalid !== 1'b0) begin n_errors++; $display("FAIL reset_rvalid: got %b expected 0", s_rvalid); end
    n_checks++; if (s_rlast !== 1'b0) begin n_errors++; $display("FAIL reset_rlast: got %b expected 0", s_rlast); end
    n_checks++; if (s_rdata !== 32'h0) begin n_errors++; $display("FAIL reset_rdata: got %h expected 0", s_rdata); end
    @(negedge clk); rst = 1'b0;
    #1;
    n_checks++; if (s_arready !== 1'b0) begin n_errors++; $display("FAIL release_arready_early: got %b expected 0", s_arready); end
    @(negedge clk);
    n_checks++; if (s_arready !== 1'b1) begin n_errors++; $display("FAIL release_arready: got %b expected 1", s_arready); end
  endtask

  task automatic test_line_burst();
    int nb; bit tmo; logic [31:0] exp_d; logic exp_l;
    issue_ar(32'h20, 3'd7, tmo);
    n_checks++; if (tmo) begin n_errors++; $display("FAIL line_ar: arready timeout got 1 expected 0"); end
    run_burst(-1, 0, nb, tmo);
    n_checks++; if (tmo || nb != 8) begin n_errors++; $display("FAIL line_count: got %0d beats (tmo %0d) expected 8", nb, tmo); end
    for (int i = 0; i < 8; i++) begin
      exp_d = 32'h1000_0008 + 32'(i); exp_l = (i == 7);
      n_checks++;
      if (got_data[i] !== exp_d || got_last[i] !== exp_l) begin
        n_errors++; $display("FAIL line_beat%0d: got %h/%b expected %h/%b", i, got_data[i], got_last[i], exp_d, exp_l);
      end
    end
    n_checks++; if (got_edge[0] != 4) begin n_errors++; $display("FAIL line_first_edge: got T+%0d expected T+4", got_edge[0]); end
    for (int i = 1; i < 8; i++) begin
      n_checks++;
      if (got_edge[i] - got_edge[i-1] != 2) begin
        n_errors++; $display("FAIL line_spacing%0d: got %0d expected 2", i, got_edge[i] - got_edge[i-1]);
      end
    end
    @(negedge clk);
    n_checks++; if (s_arready !== 1'b1 || s_rvalid !== 1'b0) begin n_errors++; $display("FAIL line_end: got arready %b rvalid %b expected 1 0", s_arready, s_rvalid); end
  endtask

  task automatic test_single();
    int nb; bit tmo;
    issue_ar(32'h46, 3'd0, tmo);
    run_burst(-1, 0, nb, tmo);
    n_checks++; if (tmo || nb != 1) begin n_errors++; $display("FAIL single_count: got %0d beats expected 1", nb); end
    n_checks++; if (got_data[0] !== 32'h1000_0011 || got_last[0] !== 1'b1) begin n_errors++; $display("FAIL single_beat: got %h/%b expected 10000011/1", got_data[0], got_last[0]); end
    @(negedge clk);
    n_checks++; if (s_arready !== 1'b1 || s_rvalid !== 1'b0) begin n_errors++; $display("FAIL single_idle: got arready %b rvalid %b expected 1 0", s_arready, s_rvalid); end
  endtask

  task automatic test_alias();
    int nb; bit tmo;
    issue_ar(32'hFFFF_C024, 3'd0, tmo);
    run_burst(-1, 0, nb, tmo);
    n_checks++; if (tmo || nb != 1 || got_data[0] !== 32'h1000_0009) begin n_errors++; $display("FAIL alias_beat: got %h (%0d beats) expected 10000009 (1 beat)", got_data[0], nb); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int nb; bit tmo; logic [31:0] exp_d;
    issue_ar(32'h20, 3'd7, tmo);
    run_burst(2, 3, nb, tmo);
    n_checks++; if (tmo || nb != 8) begin n_errors++; $display("FAIL bp_count: got %0d beats expected 8", nb); end
    n_checks++; if (n_hold != 3) begin n_errors++; $display("FAIL bp_stall_len: got %0d expected 3", n_hold); end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (hold_data[i] !== 32'h1000_000A || hold_vld[i] !== 1'b1) begin
        n_errors++; $display("FAIL bp_hold%0d: got %h/%b expected 1000000a/1", i, hold_data[i], hold_vld[i]);
      end
    end
    for (int i = 0; i < 8; i++) begin
      exp_d = 32'h1000_0008 + 32'(i);
      n_checks++;
      if (got_data[i] !== exp_d || got_last[i] !== (i == 7)) begin
        n_errors++; $display("FAIL bp_beat%0d: got %h/%b expected %h", i, got_data[i], got_last[i], exp_d);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    int nb; bit tmo;
    logic [31:0] exp_d [4];
    exp_d[0] = 32'hA5A5_0FFE; exp_d[1] = 32'hA5A5_0FFF; exp_d[2] = 32'h1000_0000; exp_d[3] = 32'h1000_0001;
    issue_ar(32'((DEPTH - 2) * 4), 3'd3, tmo);
    run_burst(-1, 0, nb, tmo);
    n_checks++; if (tmo || nb != 4) begin n_errors++; $display("FAIL wrap_count: got %0d beats expected 4", nb); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (got_data[i] !== exp_d[i] || got_last[i] !== (i == 3)) begin
        n_errors++; $display("FAIL wrap_beat%0d: got %h/%b expected %h", i, got_data[i], got_last[i], exp_d[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int nb; bit tmo; int cnt; int k; bit fired; int resid;
    issue_ar(32'h20, 3'd7, tmo);
    s_rready = 1'b1; cnt = 0; k = 0; fired = 0;
    while (!fired && k < 200) begin
      @(negedge clk); k++;
      if (s_rvalid) begin if (cnt == 3) fired = 1; else cnt++; end
    end
    n_checks++; if (!fired) begin n_errors++; $display("FAIL rstmid_beat4: got no fourth beat expected one"); end
    rst = 1'b1;
    #1;
    n_checks++; if (s_rvalid !== 1'b0 || s_rlast !== 1'b0 || s_arready !== 1'b0) begin n_errors++; $display("FAIL rstmid_async: got rvalid %b rlast %b arready %b expected 0 0 0", s_rvalid, s_rlast, s_arready); end
    @(negedge clk); @(negedge clk); rst = 1'b0;
    resid = 0;
    @(negedge clk);
    n_checks++; if (s_arready !== 1'b1) begin n_errors++; $display("FAIL rstmid_arready: got %b expected 1", s_arready); end
    for (int i = 0; i < 8; i++) begin if (s_rvalid) resid++; @(negedge clk); end
    n_checks++; if (resid != 0) begin n_errors++; $display("FAIL rstmid_residual: got %0d beats expected 0", resid); end
    issue_ar(32'h20, 3'd7, tmo);
    run_burst(-1, 0, nb, tmo);
    n_checks++; if (tmo || nb != 8) begin n_errors++; $display("FAIL rstmid_reissue_count: got %0d expected 8", nb); end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (got_data[i] !== 32'h1000_0008 + 32'(i)) begin
        n_errors++; $display("FAIL rstmid_reissue%0d: got %h expected %h", i, got_data[i], 32'h1000_0008 + 32'(i));
      end
    end
    @(negedge clk);
  endtask

  task automatic test_ar_hold();
    int nb; bit tmo;
    issue_ar(32'h20, 3'd1, tmo);
    s_arvalid = 1'b1; s_araddr = 32'h48; s_arlen = 3'd0;
    run_burst(-1, 0, nb, tmo);
    n_checks++; if (tmo || nb != 2 || got_data[0] !== 32'h1000_0008 || got_data[1] !== 32'h1000_0009) begin
      n_errors++; $display("FAIL hold_first: got %0d beats %h %h expected 2 beats 10000008 10000009", nb, got_data[0], got_data[1]);
    end
    n_checks++; if (ar_hi != 0) begin n_errors++; $display("FAIL hold_arready_busy: got %0d cycles high expected 0", ar_hi); end
    @(negedge clk);
    n_checks++; if (s_arready !== 1'b1) begin n_errors++; $display("FAIL hold_arready_after: got %b expected 1", s_arready); end
    @(posedge clk); #1 s_arvalid = 1'b0;
    run_burst(-1, 0, nb, tmo);
    n_checks++; if (tmo || nb != 1 || got_data[0] !== 32'h1000_0012 || got_last[0] !== 1'b1) begin
      n_errors++; $display("FAIL hold_second: got %0d beats %h/%b expected 1 beat 10000012/1", nb, got_data[0], got_last[0]);
    end
    n_checks++; if (got_edge[0] != 4) begin n_errors++; $display("FAIL hold_second_edge: got T+%0d expected T+4", got_edge[0]); end
    @(negedge clk);
  endtask

  task automatic test_load_during_wait();
    int nb; bit tmo;
    issue_ar(32'h20, 3'd1, tmo);
    ld_en = 1'b1; ld_addr = ADDR_BITS'(9); ld_data = 32'hDEAD_BEEF;
    run_burst(-1, 0, nb, tmo);
    n_checks++; if (tmo || nb != 2) begin n_errors++; $display("FAIL ldwait_count: got %0d expected 2", nb); end
    n_checks++; if (got_data[0] !== 32'h1000_0008) begin n_errors++; $display("FAIL ldwait_beat0: got %h expected 10000008", got_data[0]); end
    n_checks++; if (got_data[1] !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL ldwait_beat1: got %h expected deadbeef", got_data[1]); end
    @(negedge clk);
  endtask

  initial begin
    s_araddr = '0; s_arlen = '0; s_arvalid = 1'b0; s_rready = 1'b1;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    test_reset();
    preload_all();
    test_line_burst();
    test_single();
    test_alias();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    test_ar_hold();
    test_load_during_wait();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
